// File: rtl/beta_recursion_pkg.sv
// Shared constants, trellis tables and helpers for the max-log-MAP beta recursion.
// The trellis is the 4-state RSC code with feedback 7 and parity 5 (octal).
package beta_recursion_pkg;

  localparam int W_LLR      = 6;
  localparam int W_MET      = 10;
  localparam int WIN        = 4;
  localparam int W_ADDR     = 4;
  localparam int NUM_STATES = 4;
  localparam int W_CNT      = $clog2(WIN);
  localparam int W_SUM      = W_MET + 1;
  localparam int W_NRM      = W_MET + 2;

  localparam logic signed [W_MET-1:0] NEG_INIT = W_MET'(-256);

  // Successor of state s is held in bits [2s+1:2s]; parity of that branch in bit s.
  localparam logic [7:0] NEXT_U0 = {2'd1, 2'd3, 2'd2, 2'd0};
  localparam logic [7:0] NEXT_U1 = {2'd3, 2'd1, 2'd0, 2'd2};
  localparam logic [3:0] PAR_U0  = 4'b1100;
  localparam logic [3:0] PAR_U1  = 4'b0011;

  localparam logic signed [W_NRM-1:0] SAT_MAX = W_NRM'((1 << (W_MET - 1)) - 1);
  localparam logic signed [W_NRM-1:0] SAT_MIN = -SAT_MAX;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_state_t;

  function automatic logic signed [W_MET-1:0] saturate(input logic signed [W_NRM-1:0] x);
    logic signed [W_NRM-1:0] c;
    c = x;
    if (x > SAT_MAX) c = SAT_MAX;
    else if (x < SAT_MIN) c = SAT_MIN;
    return c[W_MET-1:0];
  endfunction

endpackage

// File: rtl/beta_recursion_if.sv
// Step-symbol input, beta-bundle output and status of the beta recursion unit.
interface beta_recursion_if;
  import beta_recursion_pkg::*;

  // Both streams transfer on a cycle where valid && ready; a producer holding
  // valid keeps its payload stable until that cycle, and valid never waits on ready.
  logic                     start;
  logic                     init_term;
  logic                     in_valid;
  logic                     in_ready;
  logic [W_ADDR-1:0]        in_addr;
  logic signed [W_LLR-1:0]  lsys;
  logic signed [W_LLR-1:0]  lpar;
  logic                     out_valid;
  logic                     out_ready;
  logic [W_ADDR-1:0]        out_addr;
  logic [4*W_MET-1:0]       out_beta;
  logic                     out_last;
  logic                     busy;
  fsm_state_t               dbg_state;
  logic [NUM_STATES-1:0]    dbg_sel;

  modport slave (
    input  start, init_term, in_valid, in_addr, lsys, lpar, out_ready,
    output in_ready, out_valid, out_addr, out_beta, out_last, busy, dbg_state, dbg_sel
  );

  modport master (
    output start, init_term, in_valid, in_addr, lsys, lpar, out_ready,
    input  in_ready, out_valid, out_addr, out_beta, out_last, busy, dbg_state, dbg_sel
  );

endinterface

// File: rtl/beta_recursion_acs.sv
// Add-compare-select for one trellis state: picks the larger of the two branch sums.
// A tie keeps the u=0 branch.
module beta_recursion_acs
  import beta_recursion_pkg::*;
(
  input  logic signed [W_MET-1:0] b_u0,
  input  logic signed [W_SUM-1:0] g_u0,
  input  logic signed [W_MET-1:0] b_u1,
  input  logic signed [W_SUM-1:0] g_u1,
  output logic signed [W_SUM-1:0] sum,
  output logic                    sel
);

  logic signed [W_SUM-1:0] s_u0;
  logic signed [W_SUM-1:0] s_u1;

  assign s_u0 = W_SUM'(b_u0) + g_u0;
  assign s_u1 = W_SUM'(b_u1) + g_u1;
  assign sel  = (s_u1 > s_u0);
  assign sum  = sel ? s_u1 : s_u0;

endmodule

// File: rtl/beta_recursion.sv
// Backward state-metric recursion over one window of WIN trellis steps, emitting
// normalised betas (b0 forced to 0) tagged with the step address.
module beta_recursion
  import beta_recursion_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  beta_recursion_if.slave io
);

  fsm_state_t               state;
  logic signed [W_MET-1:0]  met [NUM_STATES];
  logic [W_CNT-1:0]         count;
  logic signed [W_SUM-1:0]  g_sys;
  logic signed [W_SUM-1:0]  g_par;
  logic signed [W_SUM-1:0]  acs_sum [NUM_STATES];
  logic [NUM_STATES-1:0]    acs_sel;
  logic signed [W_MET-1:0]  nxt [NUM_STATES];
  logic                     accept;
  logic                     last_step;

  assign g_sys = W_SUM'(io.lsys);
  assign g_par = W_SUM'(io.lpar);

  for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
    localparam logic [1:0] N0 = NEXT_U0[2*s +: 2];
    localparam logic [1:0] N1 = NEXT_U1[2*s +: 2];
    localparam logic       P0 = PAR_U0[s];
    localparam logic       P1 = PAR_U1[s];

    beta_recursion_acs u_acs (
      .b_u0 (met[N0]),
      .g_u0 (P0 ? g_par : '0),
      .b_u1 (met[N1]),
      .g_u1 (g_sys + (P1 ? g_par : '0)),
      .sum  (acs_sum[s]),
      .sel  (acs_sel[s])
    );

    // Normalising against state 0 keeps the metrics bounded across the window.
    assign nxt[s] = saturate(W_NRM'(acs_sum[s]) - W_NRM'(acs_sum[0]));
  end

  assign io.in_ready = (state == RUN) && !io.start && (!io.out_valid || io.out_ready);
  assign accept      = io.in_valid && io.in_ready;
  assign last_step   = (count == W_CNT'(WIN - 1));
  assign io.busy     = (state != IDLE);
  assign io.dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      io.out_valid <= 1'b0;
      io.out_last  <= 1'b0;
      io.out_addr  <= '0;
      io.out_beta  <= '0;
      io.dbg_sel   <= '0;
      for (int i = 0; i < NUM_STATES; i++) met[i] <= '0;
    end else if (io.start) begin
      // A new start always (re)opens a window and drops any undelivered beat.
      state        <= RUN;
      count        <= '0;
      io.out_valid <= 1'b0;
      io.out_last  <= 1'b0;
      met[0]       <= '0;
      for (int i = 1; i < NUM_STATES; i++) met[i] <= io.init_term ? NEG_INIT : '0;
    end else begin
      case (state)
        RUN: begin
          if (io.out_valid && io.out_ready) io.out_valid <= 1'b0;
          if (accept) begin
            for (int i = 0; i < NUM_STATES; i++) met[i] <= nxt[i];
            io.out_beta  <= {nxt[3], nxt[2], nxt[1], nxt[0]};
            io.out_addr  <= io.in_addr;
            io.out_valid <= 1'b1;
            io.out_last  <= last_step;
            io.dbg_sel   <= acs_sel;
            count        <= count + 1'b1;
            if (last_step) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (io.out_valid && io.out_ready) begin
            io.out_valid <= 1'b0;
            io.out_last  <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_recursion.sv
// Directed bench for beta_recursion: drivers push hand-computed beats into a queue,
// a monitor pops and compares each beat the DUT hands over.
module tb_beta_recursion;

  logic clk;
  logic rst;

  beta_recursion_if bus ();

  beta_recursion dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {chk_sel, sel[3:0], last, addr[3:0], beta[39:0]}
  logic [49:0] exp_q[$];
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [39:0] pk(input int b0, input int b1, input int b2, input int b3);
    return {b3[9:0], b2[9:0], b1[9:0], b0[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic term);
    bus.start     = 1'b1;
    bus.init_term = term;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic drive_step(input logic [3:0] addr, input int ls, input int lp);
    bus.in_valid = 1'b1;
    bus.in_addr  = addr;
    bus.lsys     = 6'(ls);
    bus.lpar     = 6'(lp);
  endtask

  task automatic send(input logic [3:0] addr, input int ls, input int lp,
                      input logic [39:0] beta, input logic last,
                      input logic [3:0] sel, input logic chk);
    bit ok;
    exp_q.push_back({chk, sel, last, addr, beta});
    drive_step(addr, ls, lp);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("in_ready_timeout", 64'(0), 64'(1));
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("window_done", 64'(ok), 64'(1));
    check("busy_after_window", 64'(bus.busy), 64'(0));
  endtask

  // Monitor: every delivered beat must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(bus.out_addr), 64'hdead);
      end else begin
        logic [49:0] e;
        e = exp_q.pop_front();
        check("out_addr", 64'(bus.out_addr), 64'(e[43:40]));
        check("out_beta", 64'(bus.out_beta), 64'(e[39:0]));
        check("out_last", 64'(bus.out_last), 64'(e[44]));
        if (e[49]) check("acs_sel", 64'(bus.dbg_sel), 64'(e[48:45]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.init_term = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_addr   = '0;
    bus.lsys      = '0;
    bus.lpar      = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();

    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_out_beta", 64'(bus.out_beta), 64'(0));
    check("rst_out_addr", 64'(bus.out_addr), 64'(0));
    check("rst_out_last", 64'(bus.out_last), 64'(0));
    check("rst_state", 64'(bus.dbg_state), 64'(0));
    rst = 1'b0;
    tick();

    // in_valid while idle is ignored
    drive_step(4'd7, 1, 1);
    @(negedge clk);
    check("idle_in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    check("idle_busy", 64'(bus.busy), 64'(0));
    bus.in_valid = 1'b0;

    // Terminated init, first step then backpressure for 3 cycles
    do_start(1'b1);
    check("start_busy", 64'(bus.busy), 64'(1));
    send(4'd5, 3, 2, pk(0, 5, -253, -253), 1'b0, 4'b1110, 1'b1);
    check("lat1_out_valid", 64'(bus.out_valid), 64'(1));
    check("lat1_out_addr", 64'(bus.out_addr), 64'(5));
    bus.out_ready = 1'b0;
    drive_step(4'd4, 0, 0);
    repeat (3) begin
      @(negedge clk);
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_out_valid", 64'(bus.out_valid), 64'(1));
      check("bp_out_addr", 64'(bus.out_addr), 64'(5));
      check("bp_out_beta", 64'(bus.out_beta), 64'(pk(0, 5, -253, -253)));
      tick();
    end
    bus.out_ready = 1'b1;
    send(4'd4, 0, 0, pk(0, 0, 5, 5), 1'b0, 4'b0110, 1'b1);
    send(4'd3, 0, 0, pk(0, 0, 0, 0), 1'b0, 4'b1001, 1'b1);
    send(4'd2, 0, 0, pk(0, 0, 0, 0), 1'b1, 4'b0000, 1'b1);
    wait_idle();

    // All-zero init, zero LLRs: every branch ties and u=0 must win
    do_start(1'b0);
    send(4'd5, 0, 0, pk(0, 0, 0, 0), 1'b0, 4'b0000, 1'b1);
    send(4'd4, 0, 0, pk(0, 0, 0, 0), 1'b0, 4'b0000, 1'b1);
    send(4'd3, 0, 0, pk(0, 0, 0, 0), 1'b0, 4'b0000, 1'b1);
    send(4'd2, 0, 0, pk(0, 0, 0, 0), 1'b1, 4'b0000, 1'b1);
    wait_idle();

    // Extreme LLRs from terminated init
    do_start(1'b1);
    send(4'd3, -32, 31, pk(0, -1, -225, -225), 1'b0, 4'b0, 1'b0);
    send(4'd2, -32, 31, pk(0, -1, -33, 30), 1'b0, 4'b0, 1'b0);
    send(4'd1, -32, 31, pk(0, -1, 61, 30), 1'b0, 4'b0, 1'b0);
    send(4'd0, -32, 31, pk(0, 1, 1, -30), 1'b1, 4'b0, 1'b0);
    wait_idle();

    // Abort mid-window with a beat pending, start colliding with in_valid
    do_start(1'b0);
    send(4'd9, 0, 0, pk(0, 0, 0, 0), 1'b0, 4'b0, 1'b0);
    tick();
    bus.out_ready = 1'b0;
    send(4'd8, 0, 0, pk(0, 0, 0, 0), 1'b0, 4'b0, 1'b0);
    void'(exp_q.pop_back());
    drive_step(4'd7, 0, 0);
    bus.start     = 1'b1;
    bus.init_term = 1'b1;
    @(negedge clk);
    check("start_vs_in_valid_ready", 64'(bus.in_ready), 64'(0));
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check("abort_out_valid", 64'(bus.out_valid), 64'(0));
    check("abort_state", 64'(bus.dbg_state), 64'(1));
    bus.out_ready = 1'b1;
    send(4'd5, 3, 2, pk(0, 5, -253, -253), 1'b0, 4'b1110, 1'b1);
    send(4'd4, 0, 0, pk(0, 0, 5, 5), 1'b0, 4'b0110, 1'b1);
    send(4'd3, 0, 0, pk(0, 0, 0, 0), 1'b0, 4'b1001, 1'b1);
    send(4'd2, 0, 0, pk(0, 0, 0, 0), 1'b1, 4'b0000, 1'b1);
    wait_idle();

    // Reset mid-window with a beat pending
    do_start(1'b1);
    bus.out_ready = 1'b0;
    send(4'd6, 3, 2, pk(0, 5, -253, -253), 1'b0, 4'b1110, 1'b1);
    void'(exp_q.pop_back());
    rst = 1'b1;
    tick();
    check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mid_rst_out_addr", 64'(bus.out_addr), 64'(0));
    check("mid_rst_out_beta", 64'(bus.out_beta), 64'(0));
    check("mid_rst_out_last", 64'(bus.out_last), 64'(0));
    check("mid_rst_busy", 64'(bus.busy), 64'(0));
    check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("post_rst_busy", 64'(bus.busy), 64'(0));
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/beta_recursion.md
Name: beta_recursion

Overview:
- Max-log-MAP backward (beta) state-metric recursion unit for the 4-state RSC constituent code (feedback 7, parity 5, octal).
- Sits directly downstream of the backward window address counter. It consumes one trellis step per accepted symbol, tagged with the counter's address. It produces the 4 normalised beta metrics per step, with the address, for the beta store and LLR stage.
- One window per start; WIN steps per window.

Parameters:
- W_LLR, 6, signed width of lsys/lpar inputs
- W_MET, 10, signed width of each state metric
- WIN, 4, trellis steps per window (matches counter span 2..6 minus 1)
- W_ADDR, 4, width of step address tag

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse: load init metrics, begin window
- init_term  in  1  sampled with start: 1 = terminated init (0,NEG,NEG,NEG); 0 = all-zero init
- in_valid  in  1  step symbol valid
- in_ready  out  1  step symbol accepted when in_valid&&in_ready
- in_addr  in  W_ADDR  step address from backward counter
- lsys  in  W_LLR  systematic LLR incl. a-priori, signed
- lpar  in  W_LLR  parity LLR, signed
- out_valid  out  1  beta bundle valid
- out_ready  in  1  downstream accept
- out_addr  out  W_ADDR  address tag of step
- out_beta  out  4*W_MET  {b3,b2,b1,b0}, each signed
- out_last  out  1  marks final step of window
- busy  out  1  high outside IDLE

Behaviour:
- Reset: state IDLE; in_ready=0, out_valid=0, out_last=0, out_addr=0, out_beta=0, busy=0, metric regs=0, step count=0.
- Reset wins over every other input, including mid-window; the partial window is discarded.
- Trellis: state index s=2*s1+s0, a=u^s1^s0, p=a^s0, next=2a+s1. The per-state successor pairs (u=0 / u=1) are fixed:
  - s0: next 0 (p0) / next 2 (p1)
  - s1: next 2 (p0) / next 0 (p1)
  - s2: next 3 (p1) / next 1 (p0)
  - s3: next 1 (p1) / next 3 (p0)
- Branch metric: gamma = u*lsys + p*lpar, sign-extended to W_MET+1.
- ACS: b'(s) = max(b(next_u0)+g_u0, b(next_u1)+g_u1). On ties, the u=0 branch is selected.
- Normalise: subtract b'(0) from all four metrics, then saturate to [-(2^(W_MET-1)-1), 2^(W_MET-1)-1]. Normalised b(0) is therefore always 0.
- NEG = -256 (for W_MET=10).
- FSM:
  - IDLE: start -> load init, count=0, go RUN.
  - RUN: in_ready = !out_valid || out_ready.
    - On accept: the metric regs update with normalised results and the output regs load. out_valid=1 on the next cycle (latency 1), and out_addr=in_addr registered.
    - count increments. The accept with count==WIN-1 sets out_last with that beat and goes DRAIN.
  - DRAIN: in_ready=0; when out_valid&&out_ready, go IDLE.
- Output handshake: out_valid holds, with all out_* stable, until out_ready. Full throughput of 1 step/cycle when out_ready=1.
- start while RUN/DRAIN: aborts the current window. The metric regs reload from init, count=0, state RUN, and out_valid clears the same cycle. Any pending beat is dropped.
- start in the same cycle as in_valid: start has priority; the symbol is not accepted (in_ready=0 that cycle).
- in_valid while IDLE: ignored; in_ready=0.

Decomposition:
- map_pkg holds:
  - W_LLR, W_MET, NUM_STATES=4, NEG_INIT=-256
  - the next-state and parity tables
  - the saturate function
  - FSM state enum {IDLE,RUN,DRAIN}
- Sub-module beta_acs: one add-compare-select for a single state (two metric/gamma pairs in, selected sum out), instantiated 4 times. Normalise and saturate stay in the top.

Test Plan:
- Terminated init: start with init_term=1, one step lsys=3, lpar=2, addr=5 -> next cycle out_valid=1, out_addr=5, beta=(b0..b3)=(0,5,-253,-253).
- All-zero init: start with init_term=0, WIN steps lsys=0, lpar=0, addr 5,4,3,2 -> four beats, all betas 0, out_last=1 only on addr=2, then busy=0.
- Backpressure: hold out_ready=0 for 3 cycles after the first beat -> in_ready=0, out_beta/out_addr stable, no symbol lost; release -> remaining beats in order.
- Saturation: init_term=1, lpar=31, lsys=-32 repeated WIN steps -> every metric within [-511,511], b0=0 every beat.
- Abort and reset: start mid-window after 2 beats -> out_valid drops, new window restarts at count 0. Then rst mid-window -> all outputs 0 next cycle, busy=0.
- Tie rule: init all-zero, lsys=0, lpar=0 -> u=0 branch selected; compare the internal select against a golden model.
